// File: rtl/password_programmer.sv
// password_programmer: owner-side password store with verify-old / enter-new / confirm-new change flow
//   clk       in   system clock
//   rst       in   asynchronous reset, active-low
//   mode_req  in   1-cycle pulse, request password change (IDLE only)
//   key_pulse in   1-cycle pulse, confirm code switches
//   code      in   code switches, sampled on key_pulse
//   password  out  stored password to lock checker
//   busy      out  high whenever not IDLE
//   done      out  1-cycle pulse, new password committed
//   err       out  1-cycle pulse, mismatch / timeout / lock-out
//   seg       out  seven-segment pattern, bit8 always 0
//   led       out  fail-count thermometer, active-low
module password_programmer #(
  parameter int CODE_W = 4,
  parameter logic [CODE_W-1:0] DEFAULT_PW = 4'b1001,
  parameter int MAX_FAIL = 3,
  parameter int TIMEOUT_CYC = 500000000
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              mode_req,
  input  logic              key_pulse,
  input  logic [CODE_W-1:0] code,
  output logic [CODE_W-1:0] password,
  output logic              busy,
  output logic              done,
  output logic              err,
  output logic [8:0]        seg,
  output logic [2:0]        led
);
  localparam int TW = $clog2(TIMEOUT_CYC);
  typedef enum logic [2:0] {IDLE, OLD, NEW1, NEW2, LOCKED} state_t;
  state_t state_q, state_d;
  logic [CODE_W-1:0] pw_q, pw_d, tmp_q, tmp_d;
  logic [2:0] fail_q, fail_d, led_d;
  logic [TW-1:0] timer_q, timer_d;
  logic done_d, err_d, busy_d, entry_d;
  logic [8:0] seg_d;
  always_comb begin
    state_d = state_q;
    pw_d = pw_q;
    tmp_d = tmp_q;
    fail_d = fail_q;
    done_d = 1'b0;
    err_d = 1'b0;
    case (state_q)
      IDLE: if (mode_req) begin
        state_d = OLD;
        fail_d = '0;
      end
      OLD: if (key_pulse) begin
        if (code == pw_q) state_d = NEW1;
        else begin
          err_d = 1'b1;
          fail_d = fail_q + 3'd1;
          if (fail_d == 3'(MAX_FAIL)) state_d = LOCKED;
        end
      end
      NEW1: if (key_pulse) begin
        tmp_d = code;
        state_d = NEW2;
      end
      NEW2: if (key_pulse) begin
        if (code == tmp_q) begin
          pw_d = tmp_q;
          done_d = 1'b1;
          state_d = IDLE;
        end else begin
          err_d = 1'b1;
          tmp_d = '0;
          state_d = NEW1;
        end
      end
      default: ;
    endcase
    // A key_pulse on the expiry cycle is handled above and suppresses the abort
    if ((state_q == OLD || state_q == NEW1 || state_q == NEW2) && !key_pulse &&
        timer_q == TW'(TIMEOUT_CYC - 1)) begin
      err_d = 1'b1;
      state_d = IDLE;
    end
    entry_d = state_d == OLD || state_d == NEW1 || state_d == NEW2;
    timer_d = (!entry_d || key_pulse || state_d != state_q) ? '0 : timer_q + 1'b1;
    busy_d = state_d != IDLE;
    seg_d = state_d == OLD ? 9'h006 : state_d == NEW1 ? 9'h05b :
            state_d == NEW2 ? 9'h04f : state_d == LOCKED ? 9'h079 : 9'h040;
    led_d = fail_d == 3'd0 ? 3'b111 : fail_d == 3'd1 ? 3'b110 :
            fail_d == 3'd2 ? 3'b100 : 3'b000;
  end
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= IDLE;
      pw_q <= DEFAULT_PW;
      tmp_q <= '0;
      fail_q <= '0;
      timer_q <= '0;
      done <= 1'b0;
      err <= 1'b0;
      busy <= 1'b0;
      seg <= 9'h040;
      led <= 3'b111;
    end else begin
      state_q <= state_d;
      pw_q <= pw_d;
      tmp_q <= tmp_d;
      fail_q <= fail_d;
      timer_q <= timer_d;
      done <= done_d;
      err <= err_d;
      busy <= busy_d;
      seg <= seg_d;
      led <= led_d;
    end
  end
  assign password = pw_q;
endmodule
